cte_stream: RTL and testbench
=============================

# cte_stream

Parametrised streaming colour-transform engine, the successor to the fixed 8-bit CTE. It converts 4:2:2 YUV byte streams (U,Y0,V,Y1) to 24-bit-class RGB pixels and back, with component width set by parameter. Both sides use valid/ready handshakes, and an output FIFO absorbs downstream back-pressure. It sits between the pixel source and the frame-buffer writer in the image pipeline.

## Interface
- BW, 8: component width in bits (6..12).
- FIFO_DEPTH, 4: output FIFO entries, power of two, ≥4.

- clk  in  1: single clock, rising edge.
- reset  in  1: synchronous, active-low reset.
- op_mode  in  1: 0 = YUV→RGB, 1 = RGB→YUV; sampled only at group start.
- in_valid  in  1: input sample valid.
- in_ready  out  1: block accepts input this cycle.
- yuv_in  in  BW: YUV sample. Y is unsigned; U and V are two's complement.
- rgb_in  in  3*BW: {R,G,B}, unsigned.
- out_valid  out  1: FIFO head valid.
- out_ready  in  1: consumer accepts head.
- rgb_out  out  3*BW: head word (mode 0 result).
- yuv_out  out  BW: head word bits [BW-1:0] (mode 1 result).
- sat  out  1: present only with CTE_SAT_FLAG_EN; see Configuration.

## Operation
- A transfer occurs when a valid signal and its matching ready signal are both high on the same rising edge.
- Group FSM states: IDLE, Y0, V, Y1, P1, EMIT.
  - IDLE: on accept, op_mode is latched.
  - Mode 0, IDLE(U) → Y0 → V → Y1 → IDLE.
  - Mode 1, IDLE(P0) → P1 → EMIT → IDLE.
  - op_mode changes outside IDLE are ignored until the group completes.
- Mode 0 arithmetic, Q3 fixed point, internal signed width BW+7:
  - R = 8Y + 13V
  - G = 8Y − 2U − 6V
  - B = 8Y + 16U
  - Each result is rounded half-up ((x+4)>>>3), then clamped to [0, 2^BW−1].
  - Accepting V pushes pixel0 (from U, Y0, V). Accepting Y1 pushes pixel1 (from U, Y1, V).
- Mode 1 arithmetic:
  - Accepting P0 computes Y0 and stores R0, G0, B0.
  - Accepting P1 averages each channel as (a+b+1)>>1, then computes U and V from the averages and Y1 from P1.
  - Coefficients /256, each rounded as (sum+128)>>>8:
    - Y = 77R + 150G + 29B
    - U = −43R − 85G + 128B
    - V = 128R − 107G − 21B
  - Y is clamped to [0, 2^BW−1]. U and V are clamped to [−2^(BW−1), 2^(BW−1)−1].
  - EMIT pushes U, Y0, V, Y1, one per cycle whenever the FIFO is not full. It stalls while full and returns to IDLE after Y1.
  - yuv_out entries are zero-extended to 3*BW in the FIFO.
- in_ready = reset deasserted AND FIFO not full AND state ≠ EMIT.
- FIFO:
  - Write is in the same cycle as the triggering accept or EMIT step.
  - Simultaneous push and pop while full is legal only when the pop frees a slot. in_ready already reflects "full" before the pop.
  - Order is strictly preserved. Pointers wrap modulo FIFO_DEPTH.
- Reset values:
  - in_ready = 0 during reset, 1 the first cycle after reset.
  - out_valid = 0, rgb_out = 0, yuv_out = 0, sat = 0.
  - FSM returns to IDLE; FIFO and holding registers are cleared.
- Reset asserted mid-group discards the partial group and all queued entries.

## Timing
- Mode 0: pixel0 is on the output (out_valid=1) the cycle after V is accepted. Pixel1 is output the cycle after Y1 is accepted, provided the FIFO was empty.
- Mode 1: U appears 2 cycles after P1 is accepted, then Y0, V and Y1 follow on consecutive cycles if out_ready stays high.
- Sustained throughput:
  - Mode 0: 1 sample/cycle.
  - Mode 1: 2 pixels per 6 cycles.
- out_valid falls the cycle after the last entry is popped. Outputs hold stable while out_valid=1 and out_ready=0.

## Configuration
- CTE_SAT_FLAG_EN defined:
  - The `sat` port exists and travels with each FIFO entry.
  - sat is 1 with the head entry when any component of that entry was clamped.
- CTE_SAT_FLAG_EN undefined: no `sat` port, no flag storage; datapath behaviour is identical.

## Test plan
- Mode 0, BW=8, U=0x00, Y0=0x80, V=0x00, Y1=0xC8 → rgb_out 0x808080 then 0xC8C8C8, sat=0.
- Mode 0, U=0x80, Y0=0xFF, V=0x7F, Y1=0x00 → 0xFFC000 (sat=1), then 0xCE0000 (sat=1).
- Mode 1, P0=P1=0xFFFFFF → yuv_out 0x00, 0xFF, 0x00, 0xFF in that order, out_valid high for 4 consecutive cycles with out_ready=1.
- out_ready held 0, five mode-0 groups offered → in_ready drops after 4 FIFO entries. After out_ready rises, all 10 pixels arrive in order with none lost.
- reset pulsed low after U and Y0 are accepted → out_valid=0 and the FSM is in IDLE. The next group 0x00, 0x80, 0x00, 0x80 yields 0x808080 twice.
- op_mode toggled 0→1 after U is accepted → the group still completes as YUV→RGB. The next group starts in mode 1.

Source files
------------

// File: rtl/cte_stream.sv
// Streaming colour-transform engine: 4:2:2 YUV (U,Y0,V,Y1) <-> RGB with an output FIFO.
// Optional macro CTE_SAT_FLAG_EN adds a per-entry saturation flag and the `sat` port.
module cte_stream #(
  parameter int BW         = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            op_mode,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [BW-1:0]   yuv_in,
  input  logic [3*BW-1:0] rgb_in,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [3*BW-1:0] rgb_out,
  output logic [BW-1:0]   yuv_out
`ifdef CTE_SAT_FLAG_EN
  ,
  output logic            sat
`endif
);

  localparam int SW = BW + 7;
  localparam int MW = BW + 10;
  localparam int DW = 3 * BW;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  localparam logic signed [SW-1:0] C2   = SW'(2);
  localparam logic signed [SW-1:0] C6   = SW'(6);
  localparam logic signed [SW-1:0] C8   = SW'(8);
  localparam logic signed [SW-1:0] C13  = SW'(13);
  localparam logic signed [SW-1:0] C16  = SW'(16);
  localparam logic signed [SW-1:0] RND3 = SW'(4);
  localparam logic signed [SW-1:0] MAX0 = SW'((1 << BW) - 1);

  localparam logic signed [MW-1:0] K77   = MW'(77);
  localparam logic signed [MW-1:0] K150  = MW'(150);
  localparam logic signed [MW-1:0] K29   = MW'(29);
  localparam logic signed [MW-1:0] KN43  = MW'(-43);
  localparam logic signed [MW-1:0] KN85  = MW'(-85);
  localparam logic signed [MW-1:0] K128  = MW'(128);
  localparam logic signed [MW-1:0] KN107 = MW'(-107);
  localparam logic signed [MW-1:0] KN21  = MW'(-21);
  localparam logic signed [MW-1:0] RND8  = MW'(128);
  localparam logic signed [MW-1:0] MAXY  = MW'((1 << BW) - 1);
  localparam logic signed [MW-1:0] MAXC  = MW'((1 << (BW - 1)) - 1);
  localparam logic signed [MW-1:0] MINC  = MW'(-(1 << (BW - 1)));

  typedef enum logic [2:0] {S_IDLE, S_Y0, S_V, S_Y1, S_P1, S_EMIT} state_t;

  function automatic logic signed [SW-1:0] zx0(input logic [BW-1:0] x);
    return $signed({7'b0, x});
  endfunction

  function automatic logic signed [SW-1:0] sx0(input logic [BW-1:0] x);
    return $signed({{7{x[BW-1]}}, x});
  endfunction

  function automatic logic signed [MW-1:0] zx1(input logic [BW-1:0] x);
    return $signed({10'b0, x});
  endfunction

  function automatic logic signed [SW-1:0] rnd3(input logic signed [SW-1:0] x);
    logic signed [SW-1:0] t;
    t = x + RND3;
    return t >>> 3;
  endfunction

  function automatic logic signed [MW-1:0] rnd8(input logic signed [MW-1:0] x);
    logic signed [MW-1:0] t;
    t = x + RND8;
    return t >>> 8;
  endfunction

  function automatic logic [BW-1:0] clamp0(input logic signed [SW-1:0] x);
    if (x[SW-1])      return '0;
    else if (x > MAX0) return '1;
    else               return x[BW-1:0];
  endfunction

  function automatic logic [BW-1:0] clamp_y(input logic signed [MW-1:0] x);
    if (x[MW-1])      return '0;
    else if (x > MAXY) return '1;
    else               return x[BW-1:0];
  endfunction

  function automatic logic [BW-1:0] clamp_c(input logic signed [MW-1:0] x);
    if (x < MINC)      return MINC[BW-1:0];
    else if (x > MAXC) return MAXC[BW-1:0];
    else               return x[BW-1:0];
  endfunction

`ifdef CTE_SAT_FLAG_EN
  function automatic logic clip0(input logic signed [SW-1:0] x);
    return x[SW-1] || (x > MAX0);
  endfunction

  function automatic logic clip_y(input logic signed [MW-1:0] x);
    return x[MW-1] || (x > MAXY);
  endfunction

  function automatic logic clip_c(input logic signed [MW-1:0] x);
    return (x < MINC) || (x > MAXC);
  endfunction
`endif

  function automatic logic [BW-1:0] avg(input logic [BW-1:0] a, input logic [BW-1:0] b);
    logic [BW:0] s;
    s = {1'b0, a} + {1'b0, b} + 1'b1;
    return s[BW:1];
  endfunction

  state_t          state_q, state_d;
  logic [BW-1:0]   u_q, u_d, y0_q, y0_d, v_q, v_d, y1_q, y1_d;
  logic [BW-1:0]   r0_q, r0_d, g0_q, g0_d, b0_q, b0_d;
  logic [1:0]      idx_q, idx_d;
  logic [DW-1:0]   mem_q [FIFO_DEPTH];
  logic [DW-1:0]   mem_d [FIFO_DEPTH];
  logic [AW-1:0]   wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic            full, accept, pop, push;
  logic [DW-1:0]   push_data;
  logic [BW-1:0]   r_in, g_in, b_in;
  logic [BW-1:0]   p_y, p_v, r_a, g_a, b_a, emit_c;
  logic signed [SW-1:0] r_x, g_x, b_x;
  logic signed [MW-1:0] yl_x, u_x, v_x;
  logic [DW-1:0]   pix;

  assign {r_in, g_in, b_in} = rgb_in;
  assign full      = (cnt_q == FULL_CNT);
  assign in_ready  = reset && !full && (state_q != S_EMIT);
  assign accept    = in_valid && in_ready;
  assign out_valid = (cnt_q != '0);
  assign pop       = out_valid && out_ready;
  assign rgb_out   = mem_q[rd_q];
  assign yuv_out   = mem_q[rd_q][BW-1:0];

  // Pixel0 uses the V arriving now with the held Y0; pixel1 uses the Y1 arriving now with the held V.
  always_comb begin
    p_y  = (state_q == S_V) ? y0_q : yuv_in;
    p_v  = (state_q == S_V) ? yuv_in : v_q;
    r_x  = rnd3(C8 * zx0(p_y) + C13 * sx0(p_v));
    g_x  = rnd3(C8 * zx0(p_y) - C2 * sx0(u_q) - C6 * sx0(p_v));
    b_x  = rnd3(C8 * zx0(p_y) + C16 * sx0(u_q));
    pix  = {clamp0(r_x), clamp0(g_x), clamp0(b_x)};
    r_a  = avg(r0_q, r_in);
    g_a  = avg(g0_q, g_in);
    b_a  = avg(b0_q, b_in);
    yl_x = rnd8(K77 * zx1(r_in) + K150 * zx1(g_in) + K29 * zx1(b_in));
    u_x  = rnd8(KN43 * zx1(r_a) + KN85 * zx1(g_a) + K128 * zx1(b_a));
    v_x  = rnd8(K128 * zx1(r_a) + KN107 * zx1(g_a) + KN21 * zx1(b_a));
    case (idx_q)
      2'd0:    emit_c = u_q;
      2'd1:    emit_c = y0_q;
      2'd2:    emit_c = v_q;
      default: emit_c = y1_q;
    endcase
  end

`ifdef CTE_SAT_FLAG_EN
  logic su_q, su_d, sy0_q, sy0_d, sv_q, sv_d, sy1_q, sy1_d;
  logic smem_q [FIFO_DEPTH];
  logic smem_d [FIFO_DEPTH];
  logic push_sat, emit_sat, pix_sat;

  assign sat     = smem_q[rd_q];
  assign pix_sat = clip0(r_x) || clip0(g_x) || clip0(b_x);

  always_comb begin
    case (idx_q)
      2'd0:    emit_sat = su_q;
      2'd1:    emit_sat = sy0_q;
      2'd2:    emit_sat = sv_q;
      default: emit_sat = sy1_q;
    endcase
  end
`endif

  always_comb begin
    state_d   = state_q;
    u_d       = u_q;
    y0_d      = y0_q;
    v_d       = v_q;
    y1_d      = y1_q;
    r0_d      = r0_q;
    g0_d      = g0_q;
    b0_d      = b0_q;
    idx_d     = idx_q;
    push      = 1'b0;
    push_data = '0;
`ifdef CTE_SAT_FLAG_EN
    su_d      = su_q;
    sy0_d     = sy0_q;
    sv_d      = sv_q;
    sy1_d     = sy1_q;
    push_sat  = 1'b0;
`endif
    case (state_q)
      S_IDLE: if (accept) begin
        if (!op_mode) begin
          u_d     = yuv_in;
          state_d = S_Y0;
        end else begin
          r0_d    = r_in;
          g0_d    = g_in;
          b0_d    = b_in;
          y0_d    = clamp_y(yl_x);
`ifdef CTE_SAT_FLAG_EN
          sy0_d   = clip_y(yl_x);
`endif
          state_d = S_P1;
        end
      end
      S_Y0: if (accept) begin
        y0_d    = yuv_in;
        state_d = S_V;
      end
      S_V: if (accept) begin
        v_d       = yuv_in;
        push      = 1'b1;
        push_data = pix;
`ifdef CTE_SAT_FLAG_EN
        push_sat  = pix_sat;
`endif
        state_d   = S_Y1;
      end
      S_Y1: if (accept) begin
        push      = 1'b1;
        push_data = pix;
`ifdef CTE_SAT_FLAG_EN
        push_sat  = pix_sat;
`endif
        state_d   = S_IDLE;
      end
      S_P1: if (accept) begin
        u_d     = clamp_c(u_x);
        v_d     = clamp_c(v_x);
        y1_d    = clamp_y(yl_x);
`ifdef CTE_SAT_FLAG_EN
        su_d    = clip_c(u_x);
        sv_d    = clip_c(v_x);
        sy1_d   = clip_y(yl_x);
`endif
        idx_d   = 2'd0;
        state_d = S_EMIT;
      end
      S_EMIT: if (!full) begin
        push      = 1'b1;
        push_data = {{(2*BW){1'b0}}, emit_c};
`ifdef CTE_SAT_FLAG_EN
        push_sat  = emit_sat;
`endif
        idx_d     = idx_q + 2'd1;
        if (idx_q == 2'd3) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
`ifdef CTE_SAT_FLAG_EN
    smem_d = smem_q;
`endif
    if (push) begin
      mem_d[wr_q] = push_data;
`ifdef CTE_SAT_FLAG_EN
      smem_d[wr_q] = push_sat;
`endif
      wr_d = wr_q + 1'b1;
    end
    if (pop) rd_d = rd_q + 1'b1;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      u_q     <= '0;
      y0_q    <= '0;
      v_q     <= '0;
      y1_q    <= '0;
      r0_q    <= '0;
      g0_q    <= '0;
      b0_q    <= '0;
      idx_q   <= '0;
      mem_q   <= '{default: '0};
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      u_q     <= u_d;
      y0_q    <= y0_d;
      v_q     <= v_d;
      y1_q    <= y1_d;
      r0_q    <= r0_d;
      g0_q    <= g0_d;
      b0_q    <= b0_d;
      idx_q   <= idx_d;
      mem_q   <= mem_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef CTE_SAT_FLAG_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      su_q   <= 1'b0;
      sy0_q  <= 1'b0;
      sv_q   <= 1'b0;
      sy1_q  <= 1'b0;
      smem_q <= '{default: 1'b0};
    end else begin
      su_q   <= su_d;
      sy0_q  <= sy0_d;
      sv_q   <= sv_d;
      sy1_q  <= sy1_d;
      smem_q <= smem_d;
    end
  end
`endif

endmodule

// File: tb/tb_cte_stream.sv
// Scoreboard bench for cte_stream: directed vectors plus random groups against an integer model.
module tb_cte_stream;
  localparam int BW  = 8;
  localparam int FD  = 4;
  localparam int DW  = 3 * BW;
  localparam int TMO = 300;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          s;
  } ent_t;

  logic          clk, reset, op_mode, in_valid, in_ready, out_valid, out_ready;
  logic [BW-1:0] yuv_in, yuv_out;
  logic [DW-1:0] rgb_in, rgb_out;
`ifdef CTE_SAT_FLAG_EN
  logic          sat;
`endif

  ent_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   n_acc  = 0;
  int   ready_mode = 1;

  cte_stream #(.BW(BW), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .reset(reset), .op_mode(op_mode), .in_valid(in_valid), .in_ready(in_ready),
    .yuv_in(yuv_in), .rgb_in(rgb_in), .out_valid(out_valid), .out_ready(out_ready),
    .rgb_out(rgb_out), .yuv_out(yuv_out)
`ifdef CTE_SAT_FLAG_EN
    , .sat(sat)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
    end
  endtask

  // ---------------- reference model (integer arithmetic from the colour equations)
  function automatic int sx(input logic [BW-1:0] x);
    return x[BW-1] ? int'(x) - (1 << BW) : int'(x);
  endfunction

  function automatic int clampi(input int x, input int lo, input int hi, inout logic s);
    if (x < lo) begin s = 1'b1; return lo; end
    if (x > hi) begin s = 1'b1; return hi; end
    return x;
  endfunction

  function automatic ent_t m_pix(input logic [BW-1:0] u, input logic [BW-1:0] y, input logic [BW-1:0] v);
    int   yy, uu, vv, mx, r, g, b;
    logic s;
    ent_t e;
    yy = int'(y); uu = sx(u); vv = sx(v); mx = (1 << BW) - 1; s = 1'b0;
    r = clampi((8*yy + 13*vv + 4) >>> 3, 0, mx, s);
    g = clampi((8*yy - 2*uu - 6*vv + 4) >>> 3, 0, mx, s);
    b = clampi((8*yy + 16*uu + 4) >>> 3, 0, mx, s);
    e.data = {BW'(r), BW'(g), BW'(b)};
    e.s    = s;
    return e;
  endfunction

  function automatic ent_t m_comp(input int v, input logic s);
    ent_t        e;
    logic [BW-1:0] t;
    t = BW'(v);
    e.data = {{(2*BW){1'b0}}, t};
    e.s    = s;
    return e;
  endfunction

  task automatic push_rgb_model(input logic [DW-1:0] p0, input logic [DW-1:0] p1);
    int   r0, g0, b0, r1, g1, b1, ra, ga, ba, mx, hi, lo, y0, y1, u, v;
    logic s_y0, s_y1, s_u, s_v;
    r0 = int'(p0[3*BW-1:2*BW]); g0 = int'(p0[2*BW-1:BW]); b0 = int'(p0[BW-1:0]);
    r1 = int'(p1[3*BW-1:2*BW]); g1 = int'(p1[2*BW-1:BW]); b1 = int'(p1[BW-1:0]);
    ra = (r0 + r1 + 1) >> 1; ga = (g0 + g1 + 1) >> 1; ba = (b0 + b1 + 1) >> 1;
    mx = (1 << BW) - 1; hi = (1 << (BW-1)) - 1; lo = -(1 << (BW-1));
    s_y0 = 0; s_y1 = 0; s_u = 0; s_v = 0;
    y0 = clampi((77*r0 + 150*g0 + 29*b0 + 128) >>> 8, 0, mx, s_y0);
    y1 = clampi((77*r1 + 150*g1 + 29*b1 + 128) >>> 8, 0, mx, s_y1);
    u  = clampi((-43*ra - 85*ga + 128*ba + 128) >>> 8, lo, hi, s_u);
    v  = clampi((128*ra - 107*ga - 21*ba + 128) >>> 8, lo, hi, s_v);
    exp_q.push_back(m_comp(u, s_u));
    exp_q.push_back(m_comp(y0, s_y0));
    exp_q.push_back(m_comp(v, s_v));
    exp_q.push_back(m_comp(y1, s_y1));
  endtask

  function automatic ent_t mk(input logic [DW-1:0] d, input logic s);
    ent_t e;
    e.data = d;
    e.s    = s;
    return e;
  endfunction

  // ---------------- stimulus
  task automatic send(input logic m, input logic [BW-1:0] y, input logic [DW-1:0] p);
    int n;
    n = 0;
    @(negedge clk);
    op_mode = m; yuv_in = y; rgb_in = p; in_valid = 1'b1;
    while (!in_ready && n < TMO) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!in_ready) begin
      errors++;
      $display("FAIL accept_timeout got=in_ready_low exp=accept_within_%0d t=%0t", TMO, $time);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    n_acc++;
    #1 in_valid = 1'b0;
  endtask

  function automatic logic later_op(input int kind);
    if (kind == 0) return 1'b0;
    if (kind == 1) return 1'b1;
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [BW-1:0] rnd_c();
    case ($urandom_range(0, 3))
      0:       return '0;
      1:       return '1;
      default: return BW'($urandom);
    endcase
  endfunction

  task automatic run_yuv_group(input logic [BW-1:0] u, input logic [BW-1:0] y0, input logic [BW-1:0] v,
                               input logic [BW-1:0] y1, input int kind, input bit use_model);
    send(1'b0, u, DW'($urandom));
    send(later_op(kind), y0, DW'($urandom));
    if (use_model) exp_q.push_back(m_pix(u, y0, v));
    send(later_op(kind), v, DW'($urandom));
    if (use_model) exp_q.push_back(m_pix(u, y1, v));
    send(later_op(kind), y1, DW'($urandom));
  endtask

  task automatic run_rgb_group(input logic [DW-1:0] p0, input logic [DW-1:0] p1, input int kind,
                               input bit use_model);
    if (use_model) push_rgb_model(p0, p1);
    send(1'b1, BW'($urandom), p0);
    send(later_op(kind), BW'($urandom), p1);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("drain_remaining", 64'(exp_q.size()), 64'(0));
  endtask

  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       out_ready = 1'b0;
        1:       out_ready = 1'b1;
        default: out_ready = ($urandom_range(0, 9) < 7);
      endcase
    end
  end

  // ---------------- monitor
  initial begin
    ent_t          e;
    logic          hold_v;
    logic [DW-1:0] hold_d;
    hold_v = 1'b0;
    hold_d = '0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        hold_v = 1'b0;
      end else begin
        if (hold_v) chk("hold_stable", 64'({out_valid, rgb_out}), 64'({1'b1, hold_d}));
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_output got=%0h exp=none t=%0t", rgb_out, $time);
          end else begin
            e = exp_q.pop_front();
            chk("rgb_out", 64'(rgb_out), 64'(e.data));
            chk("yuv_out", 64'(yuv_out), 64'(e.data[BW-1:0]));
`ifdef CTE_SAT_FLAG_EN
            chk("sat", 64'(sat), 64'(e.s));
`endif
          end
          hold_v = 1'b0;
        end else if (out_valid) begin
          hold_v = 1'b1;
          hold_d = rgb_out;
        end else begin
          hold_v = 1'b0;
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog got=running exp=finished t=%0t", $time);
    $fatal(1, "watchdog expired");
  end

  // ---------------- main sequence
  initial begin
    int base;
    reset = 1'b0; in_valid = 1'b0; op_mode = 1'b0; yuv_in = '0; rgb_in = '0;
    repeat (3) @(negedge clk);
    chk("reset_in_ready", 64'(in_ready), 64'(0));
    chk("reset_out_valid", 64'(out_valid), 64'(0));
    chk("reset_rgb_out", 64'(rgb_out), 64'(0));
    chk("reset_yuv_out", 64'(yuv_out), 64'(0));
    reset = 1'b1;
    #1 chk("post_reset_in_ready", 64'(in_ready), 64'(1));

    // grey pixels and pixel0/pixel1 latency
    ready_mode = 1;
    exp_q.push_back(mk(24'h808080, 1'b0));
    exp_q.push_back(mk(24'hC8C8C8, 1'b0));
    send(1'b0, 8'h00, '0);
    send(1'b0, 8'h80, '0);
    send(1'b0, 8'h00, '0);
    @(negedge clk);
    chk("pix0_latency_valid", 64'(out_valid), 64'(1));
    send(1'b0, 8'hC8, '0);
    @(negedge clk);
    chk("pix1_latency_valid", 64'(out_valid), 64'(1));
    wait_drain();

    // saturating group
    exp_q.push_back(mk(24'hFFC000, 1'b1));
    exp_q.push_back(mk(24'hCE0000, 1'b1));
    run_yuv_group(8'h80, 8'hFF, 8'h7F, 8'h00, 0, 0);
    wait_drain();

    // white RGB -> YUV with emit timing
    exp_q.push_back(mk(24'h000000, 1'b0));
    exp_q.push_back(mk(24'h0000FF, 1'b0));
    exp_q.push_back(mk(24'h000000, 1'b0));
    exp_q.push_back(mk(24'h0000FF, 1'b0));
    send(1'b1, '0, 24'hFFFFFF);
    send(1'b1, '0, 24'hFFFFFF);
    @(negedge clk);
    chk("m1_gap_valid", 64'(out_valid), 64'(0));
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("m1_emit_valid", 64'(out_valid), 64'(1));
    end
    @(negedge clk);
    chk("m1_after_valid", 64'(out_valid), 64'(0));
    wait_drain();

    // back-pressure: five groups against a stalled consumer
    ready_mode = 0;
    @(posedge clk);
    #2;
    base = n_acc;
    fork
      begin
        for (int g = 0; g < 5; g++) run_yuv_group(rnd_c(), rnd_c(), rnd_c(), rnd_c(), 2, 1);
      end
      begin
        repeat (40) @(negedge clk);
        chk("bp_in_ready_low", 64'(in_ready), 64'(0));
        chk("bp_accepted", 64'(n_acc - base), 64'(8));
        chk("bp_out_valid", 64'(out_valid), 64'(1));
        ready_mode = 1;
      end
    join
    wait_drain();

    // reset in the middle of a group
    send(1'b0, 8'h00, '0);
    send(1'b0, 8'h80, '0);
    @(negedge clk);
    reset = 1'b0;
    #1 chk("mid_reset_in_ready", 64'(in_ready), 64'(0));
    @(negedge clk);
    chk("mid_reset_out_valid", 64'(out_valid), 64'(0));
    exp_q.delete();
    reset = 1'b1;
    #1 chk("mid_reset_release_ready", 64'(in_ready), 64'(1));
    exp_q.push_back(mk(24'h808080, 1'b0));
    exp_q.push_back(mk(24'h808080, 1'b0));
    run_yuv_group(8'h00, 8'h80, 8'h00, 8'h80, 0, 0);
    wait_drain();

    // op_mode changes mid-group are ignored; next group starts in mode 1
    run_yuv_group(8'h35, 8'h9A, 8'hD0, 8'h41, 1, 1);
    run_rgb_group(24'h12F0A7, 24'hC03388, 1, 1);
    wait_drain();

    // randomized mix with random back-pressure
    ready_mode = 2;
    for (int g = 0; g < 60; g++) begin
      if ($urandom_range(0, 1) == 0)
        run_yuv_group(rnd_c(), rnd_c(), rnd_c(), rnd_c(), 2, 1);
      else
        run_rgb_group({rnd_c(), rnd_c(), rnd_c()}, {rnd_c(), rnd_c(), rnd_c()}, 2, 1);
    end
    ready_mode = 1;
    wait_drain();
    repeat (4) @(negedge clk);
    chk("final_out_valid", 64'(out_valid), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
